bus_txn_scheduler: RTL and testbench

//   Round-robin scheduler that shares the single byte-wide command bus between

---
 rtl/bus_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/bus_txn_scheduler.sv | 159 +++++++++++++++
 tb/tb_bus_txn_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
//   Shared definitions for the crypto command-bus scheduler: FSM state
//   encoding, requester index constants and the default address width.
// ---------------------------------------------------------------------------
package bus_pkg;

    // Scheduler FSM: IDLE waits for a requester, SEND streams the captured word.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Requester indices on the shared bus.
    localparam int REQ_AES = 0;
    localparam int REQ_SHA = 1;

    // Default address width; a bus word is ADDRW + 8 bits.
    localparam int DEFAULT_ADDRW = 24;

endpackage : bus_pkg

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick. Scans the request vector starting
//   one position above last_i and wrapping, and returns the first requester
//   found.
//   Ports:
//     req_i   in  N    request vector
//     last_i  in  IW   index of the most recent owner (search starts above it)
//     gnt_o   out N    one-hot winner, all zero when no request
//     idx_o   out IW   binary index of the winner (0 when no request)
//     any_o   out 1    at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic found;
    int   pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        // k runs 1..N so the previous owner is considered last.
        for (int k = 1; k <= N; k++) begin
            pos = (int'(last_i) + k) % N;
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                idx_o      = IW'(pos);
                gnt_o[pos] = 1'b1;
            end
        end
        any_o = found;
    end

endmodule : rr_arbiter

// File: rtl/bus_txn_scheduler.sv
// ---------------------------------------------------------------------------
// bus_txn_scheduler
//   Round-robin scheduler sharing one byte-wide command bus between NREQ
//   crypto FSMs. Each grant captures one (ADDRW+8)-bit word, which is then
//   streamed LSB byte first on a valid/ready byte interface. The next word
//   is accepted on the same cycle the last byte handshakes, so back-to-back
//   words leave no idle cycle on the bus.
//   Ports:
//     clk        in   1            clock, rising edge
//     rst        in   1            synchronous active-high reset
//     req_valid  in   NREQ         requester i has a word
//     req_data   in   NREQ*WORDW   word of requester i at [i*WORDW +: WORDW]
//     req_ready  out  NREQ         one-cycle accept pulse
//     out_data   out  8            current bus byte
//     out_valid  out  1            out_data valid
//     out_ready  in   1            bus consumes byte on out_valid && out_ready
//     out_last   out  1            current byte is the last of the word
//     out_src    out  IDXW         requester owning the current word
//     grant      out  NREQ         one-hot bus owner, 0 when idle
//     busy       out  1            word in flight
// ---------------------------------------------------------------------------
module bus_txn_scheduler
    import bus_pkg::*;
#(
    parameter  int NREQ   = 2,
    parameter  int ADDRW  = DEFAULT_ADDRW,
    localparam int WORDW  = ADDRW + 8,
    localparam int NBYTES = WORDW / 8,
    localparam int IDXW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WORDW-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [IDXW-1:0]       out_src,
    output logic [NREQ-1:0]       grant,
    output logic                  busy
);

    localparam int CNTW = $clog2(NBYTES) + 1;

    generate
        if ((WORDW % 8) != 0 || NREQ < 1) begin : g_bad_params
            $error("bus_txn_scheduler: WORDW must be a multiple of 8 and NREQ >= 1");
        end
    endgenerate

    // Unpack the flat request bus into one word per requester.
    logic [WORDW-1:0] req_word [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_word[gi] = req_data[gi*WORDW +: WORDW];
        end
    endgenerate

    state_t            state_q,      state_d;
    logic [WORDW-1:0]  shreg_q,      shreg_d;
    logic [CNTW-1:0]   byte_cnt_q,   byte_cnt_d;
    logic [IDXW-1:0]   cur_q,        cur_d;
    logic [IDXW-1:0]   last_grant_q, last_grant_d;

    logic [NREQ-1:0]   arb_gnt;
    logic [IDXW-1:0]   arb_idx;
    logic [IDXW-1:0]   arb_last;
    logic              arb_any;
    logic              arb_en;
    logic              last_byte;

    // While a word is in flight its owner is the most recent grant, so the
    // back-to-back pick must rotate past cur_q; last_grant_q only catches up
    // at the final handshake.
    assign arb_last = (state_q == ST_SEND) ? cur_q : last_grant_q;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req_i  (req_valid),
        .last_i (arb_last),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .any_o  (arb_any)
    );

    assign last_byte = (byte_cnt_q == CNTW'(NBYTES - 1));

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        byte_cnt_d   = byte_cnt_q;
        cur_d        = cur_q;
        last_grant_d = last_grant_q;
        req_ready    = '0;
        out_data     = 8'h00;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        out_src      = '0;
        grant        = '0;
        busy         = 1'b0;
        arb_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                arb_en = 1'b1;
            end
            ST_SEND: begin
                out_valid = 1'b1;
                out_data  = shreg_q[7:0];
                out_last  = last_byte;
                out_src   = cur_q;
                grant     = NREQ'(1) << cur_q;
                busy      = 1'b1;
                if (out_ready) begin
                    shreg_d    = shreg_q >> 8;
                    byte_cnt_d = byte_cnt_q + CNTW'(1);
                    if (last_byte) begin
                        last_grant_d = cur_q;
                        state_d      = ST_IDLE;
                        arb_en       = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Accept point: overrides the end-of-word transition to IDLE so the
        // next word follows without a bubble. No accept pulse while in reset,
        // since the captured word would be discarded.
        if (arb_en && arb_any) begin
            req_ready  = rst ? '0 : arb_gnt;
            shreg_d    = req_word[arb_idx];
            byte_cnt_d = '0;
            cur_d      = arb_idx;
            state_d    = ST_SEND;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            byte_cnt_q   <= '0;
            cur_q        <= '0;
            last_grant_q <= IDXW'(NREQ - 1);
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            byte_cnt_q   <= byte_cnt_d;
            cur_q        <= cur_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule : bus_txn_scheduler

// File: tb/tb_bus_txn_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bus_txn_scheduler
//   Randomised and directed stimulus for bus_txn_scheduler (NREQ=2,
//   ADDRW=24), checked every cycle against a transaction-level model: a byte
//   queue for the word in flight and the index of the most recent owner.
// ---------------------------------------------------------------------------
module tb_bus_txn_scheduler;

    localparam int NREQ   = 2;
    localparam int ADDRW  = 24;
    localparam int WORDW  = ADDRW + 8;
    localparam int NBYTES = WORDW / 8;
    localparam int IDXW   = 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WORDW-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic [7:0]            out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic [IDXW-1:0]       out_src;
    logic [NREQ-1:0]       grant;
    logic                  busy;

    always #5 clk = ~clk;

    bus_txn_scheduler #(.NREQ(NREQ), .ADDRW(ADDRW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_src   (out_src),
        .grant     (grant),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        if (obs !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, req, $time);
        end
    endtask

    // Requester side: pending flag and word per requester.
    logic [NREQ-1:0]  hv;
    logic [WORDW-1:0] hw [NREQ];

    // Reference model: bytes still to send, owner of that word, most recent owner.
    logic [7:0] mq [$];
    int         m_src;
    int         m_owner;

    task automatic model_reset();
        mq.delete();
        m_src   = 0;
        m_owner = NREQ - 1;
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge,
    // advance the model at the rising edge. acc = requesters accepted.
    task automatic cycle(input logic r, input logic ordy, output logic [NREQ-1:0] acc);
        bit              act, hs, last_hs, arb_en;
        int              win;
        logic [NREQ-1:0] exp_rdy;
        logic [WORDW-1:0] w;

        rst       = r;
        out_ready = ordy;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]                = hv[i];
            req_data[i*WORDW +: WORDW]  = hw[i];
        end

        @(negedge clk);
        act     = (mq.size() > 0);
        hs      = act && ordy;
        last_hs = hs && (mq.size() == 1);
        arb_en  = !act || last_hs;
        win     = -1;
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (m_owner + k) % NREQ;
            if (win < 0 && hv[j]) win = j;
        end
        exp_rdy = '0;
        if (!r && arb_en && win >= 0) exp_rdy[win] = 1'b1;

        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(act));
        chk("out_data",  32'(out_data),  act ? 32'(mq[0]) : 32'h0);
        chk("out_last",  32'(out_last),  32'(act && mq.size() == 1));
        chk("out_src",   32'(out_src),   act ? 32'(m_src) : 32'h0);
        chk("grant",     32'(grant),     act ? (32'h1 << m_src) : 32'h0);
        chk("busy",      32'(busy),      32'(act));

        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (hs) void'(mq.pop_front());
            if (exp_rdy != '0) begin
                w = hw[win];
                for (int b = 0; b < NBYTES; b++) mq.push_back(w[b*8 +: 8]);
                m_src   = win;
                m_owner = win;
                $display("TXN t=%0t src=%0d word=%08h", $time, win, w);
            end
        end
        acc = exp_rdy;
        #1;
    endtask

    // Cycle plus requester behaviour: an accepted requester drops its word
    // and scrambles req_data (must not affect the word in flight); idle
    // requesters raise a new word with probability refill_pct.
    task automatic step(input logic r, input logic ordy, input int refill_pct);
        logic [NREQ-1:0] acc;
        cycle(r, ordy, acc);
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                hv[i] = 1'b0;
                hw[i] = $urandom;
            end
            if (!hv[i] && int'($urandom_range(99)) < refill_pct) begin
                hv[i] = 1'b1;
                hw[i] = $urandom;
            end
        end
    endtask

    initial begin
        logic ordy_pat [9];
        ordy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        hv        = '0;
        for (int i = 0; i < NREQ; i++) hw[i] = $urandom;
        rst       = 1'b1;
        out_ready = 1'b1;
        req_valid = '0;
        req_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset state, nothing requested.
        repeat (2) step(1'b0, 1'b1, 0);

        // AES alone with a known word: AA, BB, CC, DD then idle.
        hv[0] = 1'b1;
        hw[0] = 32'hDDCC_BBAA;
        repeat (8) step(1'b0, 1'b1, 0);

        // Both continuously valid: alternation with no bubble.
        hv = '1;
        repeat (24) step(1'b0, 1'b1, 100);
        hv = '0;
        repeat (6) step(1'b0, 1'b1, 0);

        // SHA continuously valid, AES arrives mid-word.
        hv[1] = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step(1'b0, 1'b1, 0);
            if (!hv[1]) begin hv[1] = 1'b1; hw[1] = $urandom; end
            if (c == 6) begin hv[0] = 1'b1; hw[0] = $urandom; end
        end
        hv = '0;
        repeat (6) step(1'b0, 1'b1, 0);

        // Back-pressure pattern during one AES word.
        hv[0] = 1'b1;
        hw[0] = $urandom;
        step(1'b0, 1'b1, 0);
        for (int c = 0; c < 9; c++) step(1'b0, ordy_pat[c], 0);
        repeat (4) step(1'b0, 1'b1, 0);

        // Reset on the cycle of the second byte, then both request.
        hv[1] = 1'b1;
        hw[1] = $urandom;
        step(1'b0, 1'b1, 0);
        hv[0] = 1'b1;
        hw[0] = $urandom;
        repeat (4) step(1'b0, 1'b1, 0);
        hv[0] = 1'b1;
        step(1'b0, 1'b1, 0);
        step(1'b1, 1'b1, 0);
        hv = '0;
        step(1'b0, 1'b1, 0);
        hv = '1;
        hw[0] = $urandom;
        hw[1] = $urandom;
        repeat (12) step(1'b0, 1'b1, 0);

        // Random traffic with stalls, forfeits and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (hv[i] && $urandom_range(63) == 0) hv[i] = 1'b0;
            step(($urandom_range(299) == 0), ($urandom_range(3) != 0), 30);
        end
        hv = '0;
        repeat (10) step(1'b0, 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bus_txn_scheduler
